// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit. It takes the two register-bank read values
// and computes either a double-width product or a quotient/remainder pair into
// hi/lo, one result bit per clock. Signed operations run on magnitudes and
// apply the sign correction in a final fix-up cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    // rem is the running upper product half (MUL) or partial remainder (DIV);
    // quo starts as the magnitude of op_a and shifts into the lower product
    // half (MUL) or the quotient (DIV)
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] a_raw;
    logic             is_div;
    logic             neg_main;
    logic             neg_rem;

    logic [WIDTH-1:0]   a_in_mag;
    logic [WIDTH-1:0]   b_in_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes at accept time; op[0] marks the signed variants
    always_comb begin
        a_in_mag = op_a;
        b_in_mag = op_b;
        if (op[0] && op_a[WIDTH-1]) begin
            a_in_mag = ~op_a + WIDTH'(1);
        end
        if (op[0] && op_b[WIDTH-1]) begin
            b_in_mag = ~op_b + WIDTH'(1);
        end
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, rem} + (quo[0] ? {1'b0, b_mag} : '0);
        div_shift = {rem, quo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_mag});
        rem_next  = rem;
        quo_next  = quo;
        if (is_div) begin
            if (div_ge) begin
                rem_next = WIDTH'(div_shift - {1'b0, b_mag});
                quo_next = {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem_next = div_shift[WIDTH-1:0];
                quo_next = {quo[WIDTH-2:0], 1'b0};
            end
        end else begin
            rem_next = mul_sum[WIDTH:1];
            quo_next = {mul_sum[0], quo[WIDTH-1:1]};
        end
    end

    // Sign correction of the magnitude result, consumed in the FIX cycle
    always_comb begin
        prod_mag = {rem, quo};
        prod_fix = neg_main ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
        quo_fix  = neg_main ? (~quo + WIDTH'(1)) : quo;
        rem_fix  = neg_rem  ? (~rem + WIDTH'(1)) : rem;
    end

    // Control FSM plus datapath registers; all outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            b_mag    <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem      <= '0;
                        quo      <= a_in_mag;
                        b_mag    <= b_in_mag;
                        a_raw    <= op_a;
                        is_div   <= op[1];
                        neg_main <= op[0] & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_rem  <= op[0] & op_a[WIDTH-1];
                        count    <= '0;
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + CW'(1);
                    if (count == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (b_mag == '0) begin
                            lo       <= '1;
                            hi       <= a_raw;
                            div_zero <= 1'b1;
                        end else begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: products, quotients, divide-by-zero,
// busy/done handshake, ignored start while busy, back-to-back start and
// asynchronous reset in the middle of an operation.
module tb_mult_div_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int vectors     = 0;
    int miscompares = 0;
    int n;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_a     (op_a),
        .op_b     (op_b),
        .op       (op),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation
    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present an operation and pulse start across one rising edge (E0)
    task automatic apply_stimulus(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op    = o;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Step edges until done is seen, counting edges from E0 (E0 itself = 1)
    task automatic wait_done(input int n0, output int n_out);
        int k;
        k = n0;
        while (done !== 1'b1 && k < LAT + 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_out = k;
    endtask

    // Full operation with latency, result and handshake checks
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo,
                          input logic exp_dz);
        int lat;
        apply_stimulus(o, a, b);
        check_output({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        wait_done(1, lat);
        check_output({tag, " latency"}, 64'(lat), 64'(LAT));
        check_output({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check_output({tag, " lo"}, 64'(lo), 64'(exp_lo));
        check_output({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
        check_output({tag, " busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check_output({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    // Directed sequence
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset done", 64'(done), 64'd0);
        check_output("reset div_zero", 64'(div_zero), 64'd0);
        check_output("reset hi", 64'(hi), 64'd0);
        check_output("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] multiply cases");
        run_op("T1 multu 338*26", 2'b00, 32'd338, 32'd26, 32'h0, 32'h0000_2254, 1'b0);
        run_op("T2 mult -7*3", 2'b01, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("mult -5*-6", 2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h0000_001E, 1'b0);
        run_op("multu max*max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        $display("[TB] divide cases");
        run_op("T3 divu 949/26", 2'b10, 32'd949, 32'd26, 32'd13, 32'd36, 1'b0);
        run_op("T3 div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("T4 divu 813/0", 2'b10, 32'd813, 32'd0, 32'd813, 32'hFFFF_FFFF, 1'b1);
        run_op("div -9/0", 2'b11, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
        run_op("T4 div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_op("divu max/1", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] start while busy and start in done cycle");
        apply_stimulus(2'b00, 32'd2, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        op_a  = 32'd5;
        op_b  = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("T5 busy_after_ignored_start", 64'(busy), 64'd1);
        wait_done(11, n);
        check_output("T5 first latency", 64'(n), 64'(LAT));
        check_output("T5 first lo", 64'(lo), 64'd6);
        check_output("T5 first hi", 64'(hi), 64'd0);
        apply_stimulus(2'b00, 32'd5, 32'd5);
        check_output("T5 lo_held_after_accept", 64'(lo), 64'd6);
        check_output("T5 busy_after_back_to_back", 64'(busy), 64'd1);
        wait_done(1, n);
        check_output("T5 second latency", 64'(n), 64'(LAT));
        check_output("T5 second lo", 64'(lo), 64'd25);
        @(posedge clk);
        #1;

        $display("[TB] reset in the middle of an operation");
        apply_stimulus(2'b00, 32'd338, 32'd26);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("T6 busy_in_reset", 64'(busy), 64'd0);
        check_output("T6 hi_in_reset", 64'(hi), 64'd0);
        check_output("T6 lo_in_reset", 64'(lo), 64'd0);
        check_output("T6 done_in_reset", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        check_output("T6 no_done_after_abandon", 64'(done), 64'd0);
        check_output("T6 idle_after_abandon", 64'(busy), 64'd0);
        run_op("T6 multu 338*26 after reset", 2'b00, 32'd338, 32'd26, 32'h0, 32'h0000_2254, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
